// File: rtl/instr_mem_loader.sv
// Boot-time loader: packs a header+payload byte stream into 32-bit instruction memory writes.
// Optional trailing checksum byte enabled by defining CHECKSUM_EN.
module instr_mem_loader #(
  parameter int unsigned MEM_BYTES = 1 << 20,
  parameter int unsigned ADR_W     = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [7:0]       i_byte,
  input  logic             i_byte_valid,
  output logic             o_byte_ready,
  output logic             o_we,
  output logic [ADR_W-1:0] o_wadr,
  output logic [31:0]      o_wdata,
  output logic [3:0]       o_wstrb,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic             o_cpu_hold
);

  typedef enum logic [2:0] {
    StIdle, StHdrAdr, StHdrLen, StHdrChk, StData, StChk, StDone, StErr
  } state_e;

  localparam logic [ADR_W:0] MemLimit = (ADR_W+1)'(MEM_BYTES);

  state_e           state_q, state_d;
  logic [1:0]       byte_idx_q;
  logic [ADR_W-1:0] addr_q, len_q, rem_q, word_adr_q;
  logic [31:0]      stage_q;
  logic             we_q;
  logic [ADR_W-1:0] wadr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
`ifdef CHECKSUM_EN
  logic [7:0]       sum_q;
`endif

  logic             accept, start_ok, last_byte, hdr_bad;
  logic [ADR_W:0]   end_adr;
  logic [31:0]      word_nxt;
  logic [3:0]       lane_mask;

  assign accept    = i_byte_valid && o_byte_ready;
  assign start_ok  = i_start && (state_q == StIdle || state_q == StDone || state_q == StErr);
  assign last_byte = (rem_q == ADR_W'(1));
  // Sum kept one bit wider so a wrapping address cannot mask an overflow.
  assign end_adr   = {1'b0, addr_q} + {1'b0, len_q};
  assign hdr_bad   = (addr_q[1:0] != 2'b00) || (end_adr > MemLimit);
  assign word_nxt  = stage_q | (32'(i_byte) << {byte_idx_q, 3'b000});

  always_comb begin
    lane_mask = 4'b1111;
    unique case (byte_idx_q)
      2'd0: lane_mask = 4'b0001;
      2'd1: lane_mask = 4'b0011;
      2'd2: lane_mask = 4'b0111;
      2'd3: lane_mask = 4'b1111;
      default: lane_mask = 4'b1111;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StErr: if (i_start) state_d = StHdrAdr;
      StHdrAdr: if (accept && byte_idx_q == 2'd3) state_d = StHdrLen;
      StHdrLen: if (accept && byte_idx_q == 2'd3) state_d = StHdrChk;
      StHdrChk: begin
        if (hdr_bad) begin
          state_d = StErr;
        end else if (len_q == '0) begin
`ifdef CHECKSUM_EN
          state_d = StChk;
`else
          state_d = StDone;
`endif
        end else begin
          state_d = StData;
        end
      end
      StData: begin
        if (accept && last_byte) begin
`ifdef CHECKSUM_EN
          state_d = StChk;
`else
          state_d = StDone;
`endif
        end
      end
      StChk: begin
`ifdef CHECKSUM_EN
        if (accept) state_d = (8'(sum_q + i_byte) == 8'h00) ? StDone : StErr;
`else
        state_d = StDone;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      byte_idx_q <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      word_adr_q <= '0;
      stage_q    <= '0;
      we_q       <= 1'b0;
      wadr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
`ifdef CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      if (start_ok) begin
        byte_idx_q <= '0;
        stage_q    <= '0;
`ifdef CHECKSUM_EN
        sum_q      <= '0;
`endif
      end
      unique case (state_q)
        StHdrAdr: if (accept) begin
          addr_q[{byte_idx_q, 3'b000} +: 8] <= i_byte;
          byte_idx_q <= byte_idx_q + 2'd1;
        end
        StHdrLen: if (accept) begin
          len_q[{byte_idx_q, 3'b000} +: 8] <= i_byte;
          byte_idx_q <= byte_idx_q + 2'd1;
        end
        StHdrChk: begin
          word_adr_q <= addr_q;
          rem_q      <= len_q;
        end
        StData: if (accept) begin
          rem_q <= rem_q - ADR_W'(1);
`ifdef CHECKSUM_EN
          sum_q <= sum_q + i_byte;
`endif
          if (byte_idx_q == 2'd3 || last_byte) begin
            we_q       <= 1'b1;
            wadr_q     <= word_adr_q;
            wdata_q    <= word_nxt;
            wstrb_q    <= lane_mask;
            word_adr_q <= word_adr_q + ADR_W'(4);
            stage_q    <= '0;
            byte_idx_q <= '0;
          end else begin
            stage_q    <= word_nxt;
            byte_idx_q <= byte_idx_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_byte_ready = 1'b0;
    o_busy       = 1'b0;
    unique case (state_q)
      StHdrAdr, StHdrLen, StData: begin
        o_byte_ready = 1'b1;
        o_busy       = 1'b1;
      end
      StChk: begin
`ifdef CHECKSUM_EN
        o_byte_ready = 1'b1;
`endif
        o_busy       = 1'b1;
      end
      StHdrChk: o_busy = 1'b1;
      default: ;
    endcase
  end

  assign o_we       = we_q;
  assign o_wadr     = wadr_q;
  assign o_wdata    = wdata_q;
  assign o_wstrb    = wstrb_q;
  assign o_done     = (state_q == StDone);
  assign o_err      = (state_q == StErr);
  assign o_cpu_hold = (state_q != StDone);

endmodule
